// File: rtl/axi_rw_arbiter_pkg.sv
// Shared definitions for the IFU/LSU arbiter in front of the AXI read/write bridge.
// Holds the FSM state encoding, size/request/owner codes and the winner-select helper.
package axi_rw_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    // Returns 1 when the LSU wins. A lone requester always wins; on contention
    // the preferred owner wins.
    function automatic logic pick_lsu(input logic ifu_v, input logic lsu_v, input logic pref);
        if (ifu_v && lsu_v) return (pref == OWN_LSU);
        return lsu_v;
    endfunction

endpackage

// File: rtl/axi_rw_arbiter_watchdog.sv
// arb_watchdog: loadable down-counter bounding one bridge transaction.
// Ports: clock, reset (sync, active-high), load (loads load_val, wins over en),
//        en (decrement, saturating at 0), load_val, expired (count is 0).
module arb_watchdog #(
    parameter int W = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)                    cnt_d = load_val;
        else if (en && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/axi_rw_arbiter.sv
// axi_rw_arbiter: shares the single-port AXI read/write bridge between the IFU
// (read-only) and the LSU (read/write). One request is latched at a time, driven
// on bus_* until bus_done_i or watchdog expiry, then a one-cycle resp pulse with
// rdata/err goes back to the owner. A returned ID mismatch or a timeout sets err.
// Ports: clock, reset (sync, active-high); ifu_* and lsu_* requester ports;
//        bus_* bridge request/response ports. All outputs are registered.
// Config: AXI_ARB_RR_EN selects round-robin arbitration; undefined = fixed LSU priority.
module axi_rw_arbiter
    import axi_rw_arbiter_pkg::*;
#(
    parameter int              ADDR_W  = 32,
    parameter int              DATA_W  = 64,
    parameter int              ID_W    = 4,
    parameter logic [ID_W-1:0] IFU_ID  = 4'd0,
    parameter logic [ID_W-1:0] LSU_ID  = 4'd1,
    parameter int              TIMEOUT = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ifu_valid_i,
    input  logic [ADDR_W-1:0] ifu_addr_i,
    input  logic [1:0]        ifu_size_i,
    output logic              ifu_resp_o,
    output logic [DATA_W-1:0] ifu_rdata_o,
    output logic              ifu_err_o,
    input  logic              lsu_valid_i,
    input  logic              lsu_we_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [1:0]        lsu_size_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    output logic              lsu_resp_o,
    output logic [DATA_W-1:0] lsu_rdata_o,
    output logic              lsu_err_o,
    output logic              bus_valid_o,
    output logic              bus_req_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [1:0]        bus_size_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic [ID_W-1:0]   bus_id_o,
    input  logic              bus_done_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic [ID_W-1:0]   bus_rid_i
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              bus_valid_q, bus_valid_d;
    logic              bus_req_q, bus_req_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [1:0]        bus_size_q, bus_size_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [ID_W-1:0]   bus_id_q, bus_id_d;
    logic              ifu_resp_q, ifu_resp_d, ifu_err_q, ifu_err_d;
    logic              lsu_resp_q, lsu_resp_d, lsu_err_q, lsu_err_d;
    logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;

    logic              grant_lsu, start;
    logic              wd_load, wd_en, wd_expired;
    logic              fin, fin_err;
    logic [DATA_W-1:0] fin_data;

    assign start = (state_q == ARB_IDLE) && (ifu_valid_i || lsu_valid_i);

`ifdef AXI_ARB_RR_EN
    // Pointer names the preferred requester; after a grant it flips to the loser.
    logic ptr_q, ptr_d;

    assign grant_lsu = pick_lsu(ifu_valid_i, lsu_valid_i, ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (start) ptr_d = grant_lsu ? OWN_IFU : OWN_LSU;
    end

    always_ff @(posedge clock) begin
        if (reset) ptr_q <= OWN_LSU;
        else       ptr_q <= ptr_d;
    end
`else
    assign grant_lsu = pick_lsu(ifu_valid_i, lsu_valid_i, OWN_LSU);
`endif

    arb_watchdog #(.W(WD_W)) u_wd (
        .clock    (clock),
        .reset    (reset),
        .load     (wd_load),
        .en       (wd_en),
        .load_val (WD_W'(TIMEOUT)),
        .expired  (wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        bus_valid_d = bus_valid_q;
        bus_req_d   = bus_req_q;
        bus_addr_d  = bus_addr_q;
        bus_size_d  = bus_size_q;
        bus_wdata_d = bus_wdata_q;
        bus_id_d    = bus_id_q;
        // Response fields are non-zero only during the RESP cycle.
        ifu_resp_d  = 1'b0;
        ifu_rdata_d = '0;
        ifu_err_d   = 1'b0;
        lsu_resp_d  = 1'b0;
        lsu_rdata_d = '0;
        lsu_err_d   = 1'b0;
        wd_load     = 1'b0;
        wd_en       = 1'b0;
        fin         = 1'b0;
        fin_err     = 1'b0;
        fin_data    = '0;

        case (state_q)
            ARB_IDLE: begin
                if (start) begin
                    state_d     = ARB_BUSY;
                    bus_valid_d = 1'b1;
                    wd_load     = 1'b1;
                    if (grant_lsu) begin
                        owner_d     = OWN_LSU;
                        bus_req_d   = lsu_we_i;
                        bus_addr_d  = lsu_addr_i;
                        bus_size_d  = lsu_size_i;
                        bus_wdata_d = lsu_wdata_i;
                        bus_id_d    = LSU_ID;
                    end else begin
                        owner_d     = OWN_IFU;
                        bus_req_d   = REQ_READ;
                        bus_addr_d  = ifu_addr_i;
                        bus_size_d  = ifu_size_i;
                        bus_wdata_d = '0;
                        bus_id_d    = IFU_ID;
                    end
                end
            end
            ARB_BUSY: begin
                wd_en = 1'b1;
                // Done wins over a same-cycle expiry.
                if (bus_done_i) begin
                    fin      = 1'b1;
                    fin_err  = (bus_rid_i != bus_id_q);
                    fin_data = (bus_req_q == REQ_WRITE) ? '0 : bus_rdata_i;
                end else if (wd_expired) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
                if (fin) begin
                    state_d     = ARB_RESP;
                    bus_valid_d = 1'b0;
                    if (owner_q == OWN_LSU) begin
                        lsu_resp_d  = 1'b1;
                        lsu_rdata_d = fin_data;
                        lsu_err_d   = fin_err;
                    end else begin
                        ifu_resp_d  = 1'b1;
                        ifu_rdata_d = fin_data;
                        ifu_err_d   = fin_err;
                    end
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IFU;
            bus_valid_q <= 1'b0;
            bus_req_q   <= REQ_READ;
            bus_addr_q  <= '0;
            bus_size_q  <= SIZE_B;
            bus_wdata_q <= '0;
            bus_id_q    <= '0;
            ifu_resp_q  <= 1'b0;
            ifu_rdata_q <= '0;
            ifu_err_q   <= 1'b0;
            lsu_resp_q  <= 1'b0;
            lsu_rdata_q <= '0;
            lsu_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            bus_valid_q <= bus_valid_d;
            bus_req_q   <= bus_req_d;
            bus_addr_q  <= bus_addr_d;
            bus_size_q  <= bus_size_d;
            bus_wdata_q <= bus_wdata_d;
            bus_id_q    <= bus_id_d;
            ifu_resp_q  <= ifu_resp_d;
            ifu_rdata_q <= ifu_rdata_d;
            ifu_err_q   <= ifu_err_d;
            lsu_resp_q  <= lsu_resp_d;
            lsu_rdata_q <= lsu_rdata_d;
            lsu_err_q   <= lsu_err_d;
        end
    end

    assign bus_valid_o = bus_valid_q;
    assign bus_req_o   = bus_req_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_size_o  = bus_size_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_id_o    = bus_id_q;
    assign ifu_resp_o  = ifu_resp_q;
    assign ifu_rdata_o = ifu_rdata_q;
    assign ifu_err_o   = ifu_err_q;
    assign lsu_resp_o  = lsu_resp_q;
    assign lsu_rdata_o = lsu_rdata_q;
    assign lsu_err_o   = lsu_err_q;

endmodule

// File: tb/tb_axi_rw_arbiter.sv
module tb_axi_rw_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ifu_valid_i = 1'b0;
    logic [31:0] ifu_addr_i = '0;
    logic [1:0]  ifu_size_i = '0;
    logic        ifu_resp_o;
    logic [63:0] ifu_rdata_o;
    logic        ifu_err_o;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [31:0] lsu_addr_i = '0;
    logic [1:0]  lsu_size_i = '0;
    logic [63:0] lsu_wdata_i = '0;
    logic        lsu_resp_o;
    logic [63:0] lsu_rdata_o;
    logic        lsu_err_o;
    logic        bus_valid_o;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic [1:0]  bus_size_o;
    logic [63:0] bus_wdata_o;
    logic [3:0]  bus_id_o;
    logic        bus_done_i = 1'b0;
    logic [63:0] bus_rdata_i = '0;
    logic [3:0]  bus_rid_i = '0;

    axi_rw_arbiter #(.TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .ifu_valid_i(ifu_valid_i), .ifu_addr_i(ifu_addr_i), .ifu_size_i(ifu_size_i),
        .ifu_resp_o(ifu_resp_o), .ifu_rdata_o(ifu_rdata_o), .ifu_err_o(ifu_err_o),
        .lsu_valid_i(lsu_valid_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
        .lsu_size_i(lsu_size_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_resp_o(lsu_resp_o), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
        .bus_valid_o(bus_valid_o), .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o),
        .bus_size_o(bus_size_o), .bus_wdata_o(bus_wdata_o), .bus_id_o(bus_id_o),
        .bus_done_i(bus_done_i), .bus_rdata_i(bus_rdata_i), .bus_rid_i(bus_rid_i)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int ifu_pulses = 0;
    int lsu_pulses = 0;

    typedef struct {
        bit          lsu;
        logic [63:0] d;
        bit          err;
    } exp_t;
    exp_t sb[$];

    task automatic push(input bit l, input logic [63:0] d, input bit e);
        exp_t x;
        x.lsu = l; x.d = d; x.err = e;
        sb.push_back(x);
    endtask

    // Scoreboard side: every resp pulse pops the oldest expected response.
    task automatic mon();
        exp_t x;
        logic [63:0] rd;
        logic re;
        if (ifu_resp_o === 1'b1 || lsu_resp_o === 1'b1) begin
            if (ifu_resp_o === 1'b1) ifu_pulses++;
            if (lsu_resp_o === 1'b1) lsu_pulses++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: ifu_resp=%0b lsu_resp=%0b, required no resp", ifu_resp_o, lsu_resp_o);
            end else begin
                x = sb.pop_front();
                rd = x.lsu ? lsu_rdata_o : ifu_rdata_o;
                re = x.lsu ? lsu_err_o : ifu_err_o;
                if ({ifu_resp_o, lsu_resp_o} !== {~x.lsu, x.lsu}) begin
                    errors++;
                    $display("FAIL sb_owner: {ifu,lsu}_resp=%b, required %b", {ifu_resp_o, lsu_resp_o}, {~x.lsu, x.lsu});
                end
                checks++;
                if (rd !== x.d) begin
                    errors++;
                    $display("FAIL sb_rdata: got %h, required %h", rd, x.d);
                end
                checks++;
                if (re !== x.err) begin
                    errors++;
                    $display("FAIL sb_err: got %0b, required %0b", re, x.err);
                end
            end
        end
    endtask

    // All time advances through here: outputs are looked at 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
        mon();
    endtask

    task automatic wait_bus(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (bus_valid_o === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bus_grant_timeout: bus_valid_o=%0b, required 1 within 40 cycles", bus_valid_o);
        end
    endtask

    task automatic pulse_done(input logic [63:0] d, input logic [3:0] id, input int delay);
        repeat (delay) tick();
        bus_done_i = 1'b1; bus_rdata_i = d; bus_rid_i = id;
        tick();
        bus_done_i = 1'b0; bus_rdata_i = '0; bus_rid_i = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({bus_valid_o, bus_req_o, bus_size_o, bus_id_o, ifu_resp_o, lsu_resp_o, ifu_err_o, lsu_err_o} !== 12'h0) begin
            errors++;
            $display("FAIL rst_ctrl: got %h, required 0", {bus_valid_o, bus_req_o, bus_size_o, bus_id_o, ifu_resp_o, lsu_resp_o, ifu_err_o, lsu_err_o});
        end
        checks++;
        if (bus_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h, required 0", bus_addr_o); end
        checks++;
        if (bus_wdata_o !== 64'h0) begin errors++; $display("FAIL rst_wdata: got %h, required 0", bus_wdata_o); end
        checks++;
        if ({ifu_rdata_o, lsu_rdata_o} !== 128'h0) begin
            errors++; $display("FAIL rst_rdata: got %h/%h, required 0", ifu_rdata_o, lsu_rdata_o);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ifu_read();
        int n; bit ok;
        push(1'b0, 64'h1122_3344_5566_7788, 1'b0);
        ifu_valid_i = 1'b1; ifu_addr_i = 32'h8000_0000; ifu_size_i = 2'd2;
        n = cyc;
        wait_bus(ok);
        checks++;
        if (cyc !== n + 1) begin errors++; $display("FAIL ifu_grant_lat: cycle %0d, required %0d", cyc, n + 1); end
        checks++;
        if ({bus_req_o, bus_id_o, bus_size_o} !== {1'b0, 4'd0, 2'd2}) begin
            errors++; $display("FAIL ifu_bus_fields: req=%0b id=%0d size=%0d, required 0/0/2", bus_req_o, bus_id_o, bus_size_o);
        end
        checks++;
        if (bus_addr_o !== 32'h8000_0000) begin errors++; $display("FAIL ifu_bus_addr: got %h, required 80000000", bus_addr_o); end
        pulse_done(64'h1122_3344_5566_7788, 4'd0, 5);
        checks++;
        if (ifu_resp_o !== 1'b1) begin errors++; $display("FAIL ifu_resp_lat: ifu_resp_o=%0b, required 1", ifu_resp_o); end
        ifu_valid_i = 1'b0;
        tick();
        checks++;
        if ({ifu_resp_o, lsu_resp_o} !== 2'b00) begin
            errors++; $display("FAIL ifu_resp_single: {ifu,lsu}_resp=%b, required 00", {ifu_resp_o, lsu_resp_o});
        end
    endtask

    task automatic test_contention();
        int r; bit ok;
        push(1'b1, 64'h0, 1'b0);
        push(1'b0, 64'hA5A5_0000_5A5A_1111, 1'b0);
        ifu_valid_i = 1'b1; ifu_addr_i = 32'h8000_0040; ifu_size_i = 2'd3;
        lsu_valid_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h8000_0100; lsu_size_i = 2'd2;
        lsu_wdata_i = 64'hDEAD_BEEF;
        wait_bus(ok);
        checks++;
        if ({bus_req_o, bus_id_o} !== {1'b1, 4'd1}) begin
            errors++; $display("FAIL cont_lsu_first: req=%0b id=%0d, required 1/1", bus_req_o, bus_id_o);
        end
        checks++;
        if ({bus_addr_o, bus_wdata_o} !== {32'h8000_0100, 64'hDEAD_BEEF}) begin
            errors++; $display("FAIL cont_lsu_fields: addr=%h wdata=%h, required 80000100/deadbeef", bus_addr_o, bus_wdata_o);
        end
        // Bridge hands back junk rdata on a write; the response must still carry 0.
        pulse_done(64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 2);
        r = cyc;
        lsu_valid_i = 1'b0; lsu_we_i = 1'b0;
        wait_bus(ok);
        checks++;
        if (cyc !== r + 2) begin errors++; $display("FAIL cont_ifu_lat: cycle %0d, required %0d", cyc, r + 2); end
        checks++;
        if ({bus_req_o, bus_id_o, bus_addr_o} !== {1'b0, 4'd0, 32'h8000_0040}) begin
            errors++; $display("FAIL cont_ifu_fields: req=%0b id=%0d addr=%h, required 0/0/80000040", bus_req_o, bus_id_o, bus_addr_o);
        end
        pulse_done(64'hA5A5_0000_5A5A_1111, 4'd0, 1);
        ifu_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        bit second_ifu; bit ok;
        logic [3:0] id2, id3;
`ifdef AXI_ARB_RR_EN
        second_ifu = 1'b1;
`else
        second_ifu = 1'b0;
`endif
        id2 = second_ifu ? 4'd0 : 4'd1;
        id3 = second_ifu ? 4'd1 : 4'd0;
        push(1'b1, 64'h0000_0000_0000_0D01, 1'b0);
        push(~second_ifu, 64'h0000_0000_0000_0D02, 1'b0);
        push(second_ifu, 64'h0000_0000_0000_0D03, 1'b0);
        ifu_valid_i = 1'b1; ifu_addr_i = 32'h8000_0200; ifu_size_i = 2'd2;
        lsu_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h8000_0300; lsu_size_i = 2'd3;
        wait_bus(ok);
        checks++;
        if (bus_id_o !== 4'd1) begin errors++; $display("FAIL b2b_r1_id: got %0d, required 1", bus_id_o); end
        pulse_done(64'h0D01, 4'd1, 1);
        lsu_addr_i = 32'h8000_0308;          // LSU follows up immediately
        wait_bus(ok);
        checks++;
        if (bus_id_o !== id2) begin errors++; $display("FAIL b2b_r2_id: got %0d, required %0d", bus_id_o, id2); end
        pulse_done(64'h0D02, id2, 1);
        if (second_ifu) ifu_valid_i = 1'b0; else lsu_valid_i = 1'b0;
        wait_bus(ok);
        checks++;
        if (bus_id_o !== id3) begin errors++; $display("FAIL b2b_r3_id: got %0d, required %0d", bus_id_o, id3); end
        pulse_done(64'h0D03, id3, 1);
        ifu_valid_i = 1'b0; lsu_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_bad_id();
        bit ok;
        push(1'b1, 64'hCAFE_F00D_0000_0042, 1'b1);
        lsu_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h8000_0400; lsu_size_i = 2'd2;
        wait_bus(ok);
        pulse_done(64'hCAFE_F00D_0000_0042, 4'd3, 3);
        checks++;
        if ({lsu_resp_o, lsu_err_o} !== 2'b11) begin
            errors++; $display("FAIL bad_id_err: resp=%0b err=%0b, required 1/1", lsu_resp_o, lsu_err_o);
        end
        lsu_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        push(1'b0, 64'h0, 1'b1);
        ifu_valid_i = 1'b1; ifu_addr_i = 32'h8000_0500; ifu_size_i = 2'd2;
        n = cyc;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ifu_resp_o === 1'b1) break;
        end
        checks++;
        if (cyc !== n + 10) begin errors++; $display("FAIL timeout_lat: resp at cycle %0d, required %0d", cyc, n + 10); end
        ifu_valid_i = 1'b0;
        tick();
        checks++;
        if ({bus_valid_o, ifu_resp_o, lsu_resp_o} !== 3'b000) begin
            errors++; $display("FAIL timeout_idle: valid/ifu/lsu=%b, required 000", {bus_valid_o, ifu_resp_o, lsu_resp_o});
        end
    endtask

    task automatic test_addr_hold();
        bit ok;
        push(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
        lsu_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h8000_0600; lsu_size_i = 2'd1;
        wait_bus(ok);
        lsu_addr_i = 32'h1234_5678; lsu_size_i = 2'd3;
        tick(); tick();
        checks++;
        if ({bus_addr_o, bus_size_o} !== {32'h8000_0600, 2'd1}) begin
            errors++; $display("FAIL addr_hold: addr=%h size=%0d, required 80000600/1", bus_addr_o, bus_size_o);
        end
        pulse_done(64'h0123_4567_89AB_CDEF, 4'd1, 1);
        lsu_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        int p, n; bit ok;
        ifu_valid_i = 1'b1; ifu_addr_i = 32'h8000_0700; ifu_size_i = 2'd2;
        wait_bus(ok);
        p = ifu_pulses + lsu_pulses;
        reset = 1'b1;
        tick();
        checks++;
        if ({bus_valid_o, bus_req_o, bus_size_o, bus_id_o, ifu_resp_o, lsu_resp_o, ifu_err_o, lsu_err_o} !== 12'h0) begin
            errors++; $display("FAIL midrst_ctrl: got %h, required 0", {bus_valid_o, bus_req_o, bus_size_o, bus_id_o, ifu_resp_o, lsu_resp_o, ifu_err_o, lsu_err_o});
        end
        checks++;
        if ({bus_addr_o, bus_wdata_o, ifu_rdata_o, lsu_rdata_o} !== 224'h0) begin
            errors++; $display("FAIL midrst_data: addr=%h wdata=%h, required 0", bus_addr_o, bus_wdata_o);
        end
        reset = 1'b0; ifu_valid_i = 1'b0;
        bus_done_i = 1'b1; bus_rdata_i = 64'h5555; bus_rid_i = 4'd0;
        tick();
        bus_done_i = 1'b0; bus_rdata_i = '0;
        repeat (3) tick();
        checks++;
        if (ifu_pulses + lsu_pulses !== p) begin
            errors++; $display("FAIL stray_done: %0d resp pulses, required %0d", ifu_pulses + lsu_pulses, p);
        end
        push(1'b1, 64'h7777_0000_0000_0001, 1'b0);
        lsu_valid_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h8000_0800; lsu_size_i = 2'd3;
        n = cyc;
        wait_bus(ok);
        checks++;
        if (cyc !== n + 1) begin errors++; $display("FAIL post_reset_grant: cycle %0d, required %0d", cyc, n + 1); end
        pulse_done(64'h7777_0000_0000_0001, 4'd1, 2);
        lsu_valid_i = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_ifu_read();
        test_contention();
        test_back_to_back();
        test_bad_id();
        test_timeout();
        test_addr_hold();
        test_reset_mid_busy();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d responses outstanding, required 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
